// File: rtl/btn_pkg.sv
// btn_pkg: shared press-classifier state type and default timing constants
package btn_pkg;
    typedef enum logic [1:0] {IDLE, PRESS, LONG} press_state_t;
    localparam int MS_TICK_100MHZ = 100_000;
    localparam int LONG_MS_DEF    = 500;
    localparam int REPEAT_MS_DEF  = 100;
endpackage

// File: rtl/press_classifier_if.sv
// press_classifier_if: button level in, classification pulses and hold time out
//   db      debounced button level
//   short_p released before the long threshold (one cycle)
//   long_p  long threshold reached (one cycle)
//   rep_p   auto-repeat while held past long (one cycle)
//   held    a press is being tracked
//   hold_ms ms elapsed in the current/last press, saturating
interface press_classifier_if #(parameter int CNT_W = 16);
    logic             db;
    logic             short_p;
    logic             long_p;
    logic             rep_p;
    logic             held;
    logic [CNT_W-1:0] hold_ms;
    modport master (output db, input short_p, long_p, rep_p, held, hold_ms);
    modport slave  (input db, output short_p, long_p, rep_p, held, hold_ms);
endinterface

// File: rtl/tick_gen_clr.sv
// tick_gen_clr: mod-M counter with synchronous clear
//   clk, reset  clock, asynchronous active-high reset
//   clr         restart the count at 0 on the next edge
//   max_tick    high while the count sits at M-1
module tick_gen_clr #(
    parameter int M = 100_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic max_tick
);
    localparam int W = $clog2(M);
    logic [W-1:0] q;
    assign max_tick = q == W'(M - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else
            q <= (clr || max_tick) ? '0 : q + 1'b1;
    end
endmodule

// File: rtl/press_classifier.sv
// press_classifier: classifies button presses as short, long or auto-repeat
//   clk, reset  clock, asynchronous active-high reset
//   bus         press_classifier_if slave: db in; pulses, held, hold_ms out
module press_classifier
    import btn_pkg::*;
#(
    parameter int TICK_M    = MS_TICK_100MHZ,
    parameter int LONG_MS   = LONG_MS_DEF,
    parameter int REPEAT_MS = REPEAT_MS_DEF,
    parameter int CNT_W     = 16
) (
    input logic clk,
    input logic reset,
    press_classifier_if.slave bus
);
    localparam int RW = $clog2(REPEAT_MS + 1);
    press_state_t     state;
    logic             db_prev, rise, fall, tick;
    logic             short_p, long_p, rep_p, held;
    logic [CNT_W-1:0] hold_ms, hold_inc;
    logic [RW-1:0]    rep_cnt;
    assign rise     = bus.db & ~db_prev;
    assign fall     = ~bus.db & db_prev;
    assign hold_inc = &hold_ms ? hold_ms : hold_ms + 1'b1;
    assign bus.short_p = short_p;
    assign bus.long_p  = long_p;
    assign bus.rep_p   = rep_p;
    assign bus.held    = held;
    assign bus.hold_ms = hold_ms;
    // prescaler restarts on every press so the first tick lands TICK_M cycles after the rise
    tick_gen_clr #(.M(TICK_M)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clr      (rise),
        .max_tick (tick)
    );
    // db_prev resets high so a button held through reset must be released first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            db_prev <= 1'b1;
            hold_ms <= '0;
            rep_cnt <= '0;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            rep_p   <= 1'b0;
            held    <= 1'b0;
        end else begin
            db_prev <= bus.db;
            short_p <= 1'b0;
            long_p  <= 1'b0;
            rep_p   <= 1'b0;
            held    <= state != IDLE;
            case (state)
                IDLE: if (rise) begin
                    state   <= PRESS;
                    hold_ms <= '0;
                end
                PRESS: if (fall) begin
                    short_p <= 1'b1;
                    state   <= IDLE;
                end else if (tick) begin
                    hold_ms <= hold_inc;
                    if (hold_inc == CNT_W'(LONG_MS)) begin
                        long_p  <= 1'b1;
                        rep_cnt <= '0;
                        state   <= LONG;
                    end
                end
                LONG: if (fall) begin
                    state <= IDLE;
                end else if (tick) begin
                    hold_ms <= hold_inc;
                    if (rep_cnt == RW'(REPEAT_MS - 1)) begin
                        rep_p   <= 1'b1;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_press_classifier.sv
// tb_press_classifier: random and directed presses checked against a timing model
module tb_press_classifier;
    localparam int M = 4, L = 5, R = 3, W = 4;
    localparam int HMAX = (1 << W) - 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   chk = 0;
    int   total = 0, bad = 0;
    int   ns = 0, nl = 0, nr = 0;
    int   s0, l0, r0;
    press_classifier_if #(.CNT_W(W)) bus ();
    press_classifier #(.TICK_M(M), .LONG_MS(L), .REPEAT_MS(R), .CNT_W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    // model: press time measured in cycles since the rise; ticks fall on multiples of M
    int   cyc = 0, t0 = 0;
    bit   trk = 0, mprev = 1;
    logic e_s = 0, e_l = 0, e_r = 0, e_h = 0;
    logic [W-1:0] e_hold = '0;
    function automatic logic [W-1:0] sat(int n);
        return W'(n > HMAX ? HMAX : n);
    endfunction
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            trk = 0; mprev = 1; cyc = 0;
            e_s = 0; e_l = 0; e_r = 0; e_h = 0; e_hold = '0;
        end else begin
            int c, n;
            cyc++;
            e_s = 0; e_l = 0; e_r = 0;
            e_h = trk;
            if (trk) begin
                c = cyc - t0;
                if (!bus.db) begin
                    n = (c - 1) / M;
                    e_hold = sat(n);
                    e_s = n < L;
                    trk = 0;
                end else if (c % M == 0) begin
                    n = c / M;
                    e_hold = sat(n);
                    e_l = n == L;
                    e_r = n > L && (n - L) % R == 0;
                end
            end else if (bus.db && !mprev) begin
                trk = 1;
                t0 = cyc;
                e_hold = '0;
            end
            mprev = bus.db;
        end
    end
    always @(negedge clk) begin
        if (chk) begin
            total++;
            if ({bus.short_p, bus.long_p, bus.rep_p, bus.held, bus.hold_ms} !== {e_s, e_l, e_r, e_h, e_hold}) begin
                bad++;
                $display("FAIL outputs t=%0t s/l/r/held/hold got=%b%b%b%b/%0d exp=%b%b%b%b/%0d",
                         $time, bus.short_p, bus.long_p, bus.rep_p, bus.held, bus.hold_ms,
                         e_s, e_l, e_r, e_h, e_hold);
            end
            ns += int'(bus.short_p);
            nl += int'(bus.long_p);
            nr += int'(bus.rep_p);
        end
    end
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask
    task automatic snap();
        s0 = ns; l0 = nl; r0 = nr;
    endtask
    task automatic press(int n, int gap);
        bus.db = 1'b1;
        step(n);
        bus.db = 1'b0;
        step(gap);
    endtask
    task automatic expect_run(string name, int s, int l, int r, int h);
        check({name, "_short"}, ns - s0, s);
        check({name, "_long"}, nl - l0, l);
        check({name, "_rep"}, nr - r0, r);
        check({name, "_hold"}, int'(bus.hold_ms), h);
        check({name, "_held"}, int'(bus.held), 0);
    endtask
    initial begin
        bus.db = 1'b0;
        @(posedge clk);
        #1 chk = 1;
        step(2);
        reset = 1'b0;
        snap();
        step(20);
        expect_run("idle", 0, 0, 0, 0);
        snap();
        press(13, 6);
        expect_run("short", 1, 0, 0, 3);
        snap();
        press(44, 6);
        expect_run("long", 0, 1, 1, 10);
        snap();
        press(20, 6);
        expect_run("edge5", 1, 0, 0, 4);
        bus.db = 1'b1;
        step(9);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        snap();
        step(5);
        check("thru_reset_held", int'(bus.held), 0);
        check("thru_reset_pulses", ns + nl + nr - s0 - l0 - r0, 0);
        bus.db = 1'b0;
        step(2);
        press(13, 6);
        expect_run("repress", 1, 0, 0, 3);
        snap();
        press(81, 6);
        expect_run("sat", 0, 1, 5, 15);
        repeat (300) begin
            bus.db = 1'b1;
            step($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) begin
                reset = 1'b1;
                step(1);
                reset = 1'b0;
            end
            step($urandom_range(0, 40));
            bus.db = 1'b0;
            step($urandom_range(1, 8));
        end
        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
